// File: rtl/program_sequencer_if.sv
// Run-control handshake between the program sequencer and the core/testbench side.
// The sequencer takes the master modport; whatever drives start/halt takes the slave modport.
interface program_sequencer_if #(
    parameter int PC_W = 32
) ();
    logic            start;
    logic            halt;
    logic [PC_W-1:0] prog_base;
    logic            core_clear;
    logic            pc_load;
    logic [PC_W-1:0] pc_load_value;
    logic            run_en;
    logic            done;
    logic            timeout;
    logic [31:0]     cycle_count;

    modport master (
        input  start, halt, prog_base,
        output core_clear, pc_load, pc_load_value, run_en, done, timeout, cycle_count
    );

    modport slave (
        output start, halt, prog_base,
        input  core_clear, pc_load, pc_load_value, run_en, done, timeout, cycle_count
    );
endinterface

// File: rtl/program_sequencer.sv
// Run controller for the single-cycle core: clears the core, loads the start PC,
// gates execution and reports completion by halt or by watchdog.
module program_sequencer #(
    parameter int INIT_CYCLES = 2,
    parameter int MAX_CYCLES  = 100000,
    parameter int PC_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    program_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_HOLD   = 3'd2,
        S_RUN    = 3'd3,
        S_FINISH = 3'd4
    } state_e;

    localparam int          CNT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [31:0] WD_LAST  = 32'(MAX_CYCLES - 1);

    state_e          state_q;
    state_e          state_next;
    logic [CNT_W-1:0] clr_cnt_q;
    logic            core_clear_q;
    logic            pc_load_q;
    logic            run_en_q;
    logic            done_q;
    logic            timeout_q;
    logic [31:0]     cycle_count_q;
    logic [PC_W-1:0] pc_load_value_q;
    logic            wd_hit;
    logic            accept;

    assign wd_hit = (MAX_CYCLES != 0) && (cycle_count_q == WD_LAST);
    assign accept = ((state_q == S_IDLE) || (state_q == S_FINISH)) && bus.start;

    always_comb begin
        // NOTE: default assignment first so every path drives state_next and no latch is inferred.
        state_next = state_q;
        case (state_q)
            S_IDLE:   if (bus.start)                  state_next = S_CLEAR;
            S_CLEAR:  if (clr_cnt_q == CNT_LAST)      state_next = S_HOLD;
            S_HOLD:   if (!bus.start)                 state_next = S_RUN;
            S_RUN:    if (bus.halt || wd_hit)         state_next = S_FINISH;
            S_FINISH: if (bus.start)                  state_next = S_CLEAR;
            default:                                  state_next = S_IDLE;
        endcase
    end

    // Control outputs are registered from the next state, so they match the state register exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            clr_cnt_q       <= '0;
            core_clear_q    <= 1'b0;
            pc_load_q       <= 1'b0;
            run_en_q        <= 1'b0;
            done_q          <= 1'b0;
            timeout_q       <= 1'b0;
            cycle_count_q   <= '0;
            pc_load_value_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_next;
            core_clear_q <= (state_next == S_CLEAR);
            pc_load_q    <= (state_next == S_HOLD);
            run_en_q     <= (state_next == S_RUN);
            done_q       <= (state_next == S_FINISH);

            if (state_q == S_CLEAR) clr_cnt_q <= clr_cnt_q + CNT_W'(1);
            else                    clr_cnt_q <= '0;

            if (accept) begin
                pc_load_value_q <= bus.prog_base;
                cycle_count_q   <= '0;
                timeout_q       <= 1'b0;
            end

            if (state_q == S_RUN) begin
                if (cycle_count_q != '1) cycle_count_q <= cycle_count_q + 32'd1;
                // halt has priority over the watchdog in the same cycle
                if (!bus.halt && wd_hit) timeout_q <= 1'b1;
            end
        end
    end

    assign bus.core_clear    = core_clear_q;
    assign bus.pc_load       = pc_load_q;
    assign bus.pc_load_value = pc_load_value_q;
    assign bus.run_en        = run_en_q;
    assign bus.done          = done_q;
    assign bus.timeout       = timeout_q;
    assign bus.cycle_count   = cycle_count_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with INIT_CYCLES=2 and a watchdog of 8 RUN cycles.
module tb_program_sequencer;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   n;

    program_sequencer_if #(.PC_W(32)) psi ();

    program_sequencer #(
        .INIT_CYCLES(2),
        .MAX_CYCLES (8),
        .PC_W       (32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (psi.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timed out");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Start a program from IDLE/FINISH, holding start for start_len accepted edges.
    task automatic launch(input logic [31:0] base, input int start_len, input int exp_hold);
        int k;
        int h;
        psi.prog_base = base;
        psi.start     = 1'b1;
        cyc(); k = 1;
        if (k >= start_len) psi.start = 1'b0;
        check("clear1_core_clear", psi.core_clear, 1);
        check("clear1_done",       psi.done, 0);
        check("clear1_pc_value",   psi.pc_load_value, base);
        check("clear1_cycle_cnt",  psi.cycle_count, 0);
        check("clear1_timeout",    psi.timeout, 0);
        cyc(); k = 2;
        if (k >= start_len) psi.start = 1'b0;
        check("clear2_core_clear", psi.core_clear, 1);
        check("clear2_pc_load",    psi.pc_load, 0);
        cyc(); k = 3;
        check("hold_pc_load",      psi.pc_load, 1);
        check("hold_core_clear",   psi.core_clear, 0);
        check("hold_pc_value",     psi.pc_load_value, base);
        h = 0;
        while (psi.pc_load === 1'b1 && h < 20) begin
            h++;
            if (k >= start_len) psi.start = 1'b0;
            cyc(); k++;
        end
        check("hold_len",          h, exp_hold);
        check("run_entry_run_en",  psi.run_en, 1);
    endtask

    // Count RUN cycles, asserting halt during RUN cycle halt_at (0 = never).
    task automatic run_prog(input int halt_at, input bit toggle, output int cnt);
        cnt = 0;
        while (psi.run_en === 1'b1 && cnt < 40) begin
            cnt++;
            check("run_no_done", psi.done, 0);
            psi.halt = (cnt == halt_at);
            if (toggle) psi.start = cnt[0];
            cyc();
        end
        psi.halt  = 1'b0;
        psi.start = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        psi.start     = 1'b0;
        psi.halt      = 1'b0;
        psi.prog_base = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done",       psi.done, 0);
        check("rst_run_en",     psi.run_en, 0);
        check("rst_core_clear", psi.core_clear, 0);
        check("rst_pc_load",    psi.pc_load, 0);
        check("rst_timeout",    psi.timeout, 0);
        check("rst_cycle_cnt",  psi.cycle_count, 0);
        check("rst_pc_value",   psi.pc_load_value, 0);
        reset = 1'b0;
        cyc();
        check("idle_done",       psi.done, 0);
        check("idle_core_clear", psi.core_clear, 0);

        // Halt on the 5th RUN cycle
        launch(32'h10, 3, 1);
        run_prog(5, 1'b0, n);
        check("t2_run_len",   n, 5);
        check("t2_done",      psi.done, 1);
        check("t2_run_en",    psi.run_en, 0);
        check("t2_cycle_cnt", psi.cycle_count, 5);
        check("t2_timeout",   psi.timeout, 0);
        cyc();
        check("t2_done_held", psi.done, 1);

        // Watchdog expiry
        launch(32'h20, 2, 1);
        run_prog(0, 1'b0, n);
        check("t3_run_len",   n, 8);
        check("t3_done",      psi.done, 1);
        check("t3_timeout",   psi.timeout, 1);
        check("t3_cycle_cnt", psi.cycle_count, 8);

        // Restart from FINISH, HOLD stretched by start, start toggled during RUN
        launch(32'h40, 5, 3);
        run_prog(3, 1'b1, n);
        check("t5_run_len",   n, 3);
        check("t5_done",      psi.done, 1);
        check("t5_timeout",   psi.timeout, 0);
        check("t5_cycle_cnt", psi.cycle_count, 3);
        check("t5_pc_value",  psi.pc_load_value, 32'h40);
        cyc();
        check("t5_stay_finish", psi.done, 1);

        // Halt coincides with the watchdog limit; also a 1-cycle start pulse
        launch(32'h80, 1, 1);
        run_prog(8, 1'b0, n);
        check("t4_run_len",   n, 8);
        check("t4_done",      psi.done, 1);
        check("t4_timeout",   psi.timeout, 0);
        check("t4_cycle_cnt", psi.cycle_count, 8);

        // Asynchronous reset in the middle of RUN
        launch(32'h55, 3, 1);
        cyc();
        cyc();
        check("t1_pre_run_en", psi.run_en, 1);
        #2 reset = 1'b1;
        #1;
        check("t1_run_en",    psi.run_en, 0);
        check("t1_done",      psi.done, 0);
        check("t1_timeout",   psi.timeout, 0);
        check("t1_cycle_cnt", psi.cycle_count, 0);
        check("t1_pc_value",  psi.pc_load_value, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc();
        check("t1_idle_done",  psi.done, 0);
        check("t1_idle_clear", psi.core_clear, 0);
        check("t1_idle_run",   psi.run_en, 0);
        cyc();
        check("t1_idle_done2", psi.done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
